// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit nibble adder.
// Processes one nibble per clock, least significant nibble first, and pulses done when the result is ready.
module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   work;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  // The nibble adder is only driven while a pass is in flight; it reads zeros otherwise.
  assign add_a     = (state == RUN) ? a_r[{idx, 2'b00} +: 4] : 4'h0;
  assign add_b     = (state == RUN) ? b_r[{idx, 2'b00} +: 4] : 4'h0;
  assign add_cin   = (state == RUN) ? carry : 1'b0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work[{idx, 2'b00} +: 4] <= add_s;
          carry                   <= add_cout;
          if (idx == LAST) begin
            idx   <= '0;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          // b_r already holds ~b for subtraction, so one overflow rule covers both operations.
          sum      <= work;
          c_out    <= carry;
          overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (work[WIDTH-1] != a_r[WIDTH-1]);
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
